// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel window reader: pixel/window layout,
// reader FSM states and the {row, col} pixel address packing.
package pixel_pkg;

   localparam int IMG_DIM   = 32;
   localparam int CH_W      = 16;
   localparam int NUM_CH    = 3;
   localparam int PIX_W     = NUM_CH * CH_W;
   localparam int TAPS      = 9;
   localparam int COORD_W   = 5;
   localparam int ADDR_W    = 16;
   localparam int ROW_SHIFT = 5;

   typedef logic [NUM_CH-1:0][CH_W-1:0] pixel_t;
   typedef pixel_t [TAPS-1:0]           window_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPT,
      OUT,
      DONE
   } state_t;

   // Observation bundle for checkers: FSM state plus the tap being generated.
   typedef struct packed {
      state_t               state;
      logic [3:0]           tap_idx;
      logic [COORD_W-1:0]   tap_row;
      logic [COORD_W-1:0]   tap_col;
      logic                 tap_in_bounds;
   } dbg_t;

   // Channel field [11:10] and the top nibble stay zero for a 32x32 image.
   function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] row,
                                                   input logic [COORD_W-1:0] col);
      return (ADDR_W'(row) << ROW_SHIFT) | ADDR_W'(col);
   endfunction

endpackage

// File: rtl/window_tap_gen.sv
// Combinational tap generator: maps a centre pixel and tap index 0..8 to the
// neighbour coordinate, its in-bounds flag and its packed memory address.
module window_tap_gen
   import pixel_pkg::*;
(
   input  logic [COORD_W-1:0] ctr_row,
   input  logic [COORD_W-1:0] ctr_col,
   input  logic [3:0]         tap_idx,
   output logic [COORD_W-1:0] tap_row,
   output logic [COORD_W-1:0] tap_col,
   output logic               in_bounds,
   output logic [ADDR_W-1:0]  tap_addr
);

   logic signed [5:0] row_off;
   logic signed [5:0] col_off;
   logic signed [5:0] row_s;
   logic signed [5:0] col_s;
   logic              idx_ok;

   always_comb begin
      row_off = 6'sd0;
      col_off = 6'sd0;
      idx_ok  = 1'b1;
      case (tap_idx)
         4'd0: begin row_off = -6'sd1; col_off = -6'sd1; end
         4'd1: begin row_off = -6'sd1; col_off =  6'sd0; end
         4'd2: begin row_off = -6'sd1; col_off =  6'sd1; end
         4'd3: begin row_off =  6'sd0; col_off = -6'sd1; end
         4'd4: begin row_off =  6'sd0; col_off =  6'sd0; end
         4'd5: begin row_off =  6'sd0; col_off =  6'sd1; end
         4'd6: begin row_off =  6'sd1; col_off = -6'sd1; end
         4'd7: begin row_off =  6'sd1; col_off =  6'sd0; end
         4'd8: begin row_off =  6'sd1; col_off =  6'sd1; end
         default: idx_ok = 1'b0;
      endcase
   end

   assign row_s = $signed({1'b0, ctr_row}) + row_off;
   assign col_s = $signed({1'b0, ctr_col}) + col_off;

   // 31+1 = 32 aliases to -32 in 6-bit signed, so one sign test catches -1 and 32.
   assign in_bounds = idx_ok && (row_s >= 6'sd0) && (col_s >= 6'sd0);
   assign tap_row   = row_s[COORD_W-1:0];
   assign tap_col   = col_s[COORD_W-1:0];
   assign tap_addr  = in_bounds ? pack_addr(tap_row, tap_col) : '0;

endmodule

// File: rtl/pixel_window_reader.sv
// Raster-scans the 32x32 pixel memory and emits a zero-padded 3x3 window per
// pixel on a valid/ready port; one tap read per cycle, nine per window.
module pixel_window_reader #(
   parameter int IMG_DIM = 32,
   parameter int CH_W    = 16,
   parameter int PIX_W   = 48
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           read_pixel_addr,
   output logic                  read_pixel_signal,
   input  logic [3*CH_W-1:0]     read_pixel_data,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [9*PIX_W-1:0]    win_data,
   output logic [4:0]            win_row,
   output logic [4:0]            win_col,
   output pixel_pkg::dbg_t       dbg
);
   import pixel_pkg::*;

   // Window handshake: a window transfers on a clock edge where win_valid and
   // win_ready are both high; while win_valid is high and win_ready low, the
   // window and its coordinates are held and no memory reads are issued.

   localparam logic [4:0] LAST = 5'(IMG_DIM - 1);

   state_t       state, state_nxt;
   logic [4:0]   row, col;
   logic [3:0]   tap_k;
   logic [4:0]   tap_row, tap_col;
   logic         in_bounds;
   logic [15:0]  tap_addr;
   logic         last_win;

   logic         iss_valid;
   logic [3:0]   iss_idx;
   logic         iss_inb;
   window_t      taps;

   window_tap_gen u_tap_gen (
      .ctr_row   (row),
      .ctr_col   (col),
      .tap_idx   (tap_k),
      .tap_row   (tap_row),
      .tap_col   (tap_col),
      .in_bounds (in_bounds),
      .tap_addr  (tap_addr)
   );

   assign last_win = (row == LAST) && (col == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FETCH;
         FETCH:   if (tap_k == 4'(TAPS - 1)) state_nxt = CAPT;
         CAPT:    state_nxt = OUT;
         OUT:     if (win_ready) state_nxt = last_win ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign read_pixel_signal = (state == FETCH) && in_bounds;
   assign read_pixel_addr   = read_pixel_signal ? tap_addr : 16'd0;
   assign busy              = (state == FETCH) || (state == CAPT) || (state == OUT);
   assign done              = (state == DONE);
   assign win_valid         = (state == OUT);
   assign win_data          = taps;
   assign win_row           = row;
   assign win_col           = col;

   assign dbg = '{state: state, tap_idx: tap_k, tap_row: tap_row,
                  tap_col: tap_col, tap_in_bounds: in_bounds};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row   <= '0;
         col   <= '0;
         tap_k <= '0;
      end else if (state == IDLE && start) begin
         row   <= '0;
         col   <= '0;
         tap_k <= '0;
      end else if (state == FETCH) begin
         tap_k <= (tap_k == 4'(TAPS - 1)) ? 4'd0 : tap_k + 4'd1;
      end else if (state == OUT && win_ready) begin
         col <= col + 5'd1;
         if (col == LAST) row <= row + 5'd1;
      end
   end

   // Read data lags the address by one cycle, so the tap index and bounds flag
   // travel one stage behind the issue to select and qualify the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_valid <= 1'b0;
         iss_idx   <= '0;
         iss_inb   <= 1'b0;
      end else begin
         iss_valid <= (state == FETCH);
         iss_idx   <= tap_k;
         iss_inb   <= in_bounds;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taps <= '0;
      end else if (iss_valid) begin
         for (int i = 0; i < TAPS; i++) begin
            if (iss_idx == 4'(i)) taps[i] <= iss_inb ? pixel_t'(read_pixel_data) : '0;
         end
      end
   end

endmodule
